proc_trace_recorder: RTL and testbench
======================================

# proc_trace_recorder

Trace-port consumer for the TinyRV1 processors. Sits on the `trace_val`/`trace_addr`/`trace_data` port driven by `ProcScycle` and the other processor variants. It captures committed-instruction trace records into an on-chip FIFO, and can start capture on an optional PC trigger and stop after a set number of records. A host or bench drains the records later over a valid/ready read port, so FPGA runs can be compared against simulator traces without a live testbench.

## Interface
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `trace_val` in 1: processor trace record valid this cycle.
- `trace_addr` in 32: PC of the committed instruction.
- `trace_data` in 32: writeback/store data of that instruction.
- `arm` in 1: single-cycle pulse; starts a capture session.
- `stop` in 1: single-cycle pulse; ends the session.
- `clear` in 1: single-cycle pulse; flushes the FIFO and counters and returns to IDLE.
- `trig_en` in 1: when 1, capture begins on the first record whose PC equals `trig_addr`.
- `trig_addr` in 32: trigger PC.
- `cap_limit` in 16: number of records per session; 0 means unlimited.
- `rd_val` out 1: FIFO head is valid.
- `rd_rdy` in 1: consumer accepts the head.
- `rd_addr` out 32: head PC; 0 when `rd_val`=0.
- `rd_data` out 32: head data; 0 when `rd_val`=0.
- `state` out 2: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- `count` out clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky flag; at least one record was dropped.
- `drop_cnt` out 16: number of dropped records; saturates at 0xFFFF.

## Operation
- Reset (`rst`=0, asynchronous): state IDLE, FIFO empty, `count`=0, `rd_val`=0, `rd_addr`=`rd_data`=0, `overflow`=0, `drop_cnt`=0. The session record counter is also cleared.
- FSM transitions:
  - IDLE → ARMED on `arm` when `trig_en`=1.
  - IDLE → CAPTURE on `arm` when `trig_en`=0.
  - ARMED → CAPTURE when `trace_val` && `trace_addr`==`trig_addr`. The matching record is itself captured.
  - CAPTURE → DONE when the session record counter reaches `cap_limit` (≠0) after a record.
  - CAPTURE → DONE on `stop`. ARMED → DONE on `stop`.
  - DONE → CAPTURE on `arm` when `trig_en`=0; DONE → ARMED on `arm` when `trig_en`=1. A new `arm` does not flush the FIFO.
- `arm` in ARMED or CAPTURE: ignored.
- Control priority within a cycle: `clear` > `stop` > `arm`. `clear` from any state goes to IDLE, empties the FIFO, and zeroes `overflow`, `drop_cnt` and the session counter. A record presented in the same cycle as `clear` is discarded.
- Record handling: a record is captured only in CAPTURE (or on the trigger match in ARMED) with `trace_val`=1. Each captured record increments the session counter, whether it is stored or dropped.
- Session counter: 16 bits, reset to 0 on every `arm`.
- Store: {`trace_addr`,`trace_data`} is pushed at the tail.
- Drop: if the FIFO is full and no pop occurs the same cycle, the record is dropped. `overflow` is set to 1 and `drop_cnt` increments, saturating.
- Pop: occurs when `rd_val` && `rd_rdy`, and removes the head. Push and pop in the same cycle leave `count` unchanged. With a simultaneous pop, a full FIFO accepts the push and nothing is dropped.
- `rd_rdy` when empty has no effect.
- Read port: show-ahead; the head is driven combinationally from the storage array. The read side operates in every state, including IDLE and DONE.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
- `count` range: 0 to DEPTH.

## Timing
- A record captured at edge N appears on `rd_val`/`rd_addr`/`rd_data` after edge N when the FIFO was empty, giving 1-cycle latency.
- `state`, `count`, `overflow` and `drop_cnt` are registered and update at the edge that consumes the event.
- The CAPTURE→DONE transition on the limit happens at the same edge as the last record is captured. A `trace_val` on the next cycle is ignored.
- Throughput: one push and one pop per cycle, sustained.
- Reset mid-session: everything returns to reset values immediately, asynchronously. Outputs are valid from the first edge after `rst` deasserts.

## Test plan
- Basic capture, DEPTH=16, `trig_en`=0, `cap_limit`=0: `arm`, then records (0x200,0x5), (0x204,0x7), (0x208,0xC). Required response:
  - `count`=3; drain returns the records in order.
  - `rd_val` falls after the third pop.
  - `state` stays CAPTURE.
- Trigger: `trig_en`=1, `trig_addr`=0x20C, PCs 0x200–0x214 stepping by 4. Required response:
  - `state`=ARMED until 0x20C, then CAPTURE.
  - FIFO holds 0x20C, 0x210, 0x214.
- Limit: `cap_limit`=2, records 0x200, 0x204, 0x208. Required response:
  - `state`=DONE at the edge capturing 0x204.
  - 0x208 is not stored; `count`=2.
- Overflow: DEPTH=16, 20 records with `rd_rdy`=0. Required response:
  - `count`=16, `overflow`=1, `drop_cnt`=4.
  - The head is the 1st record.
  - Full FIFO with a record and `rd_rdy`=1 in the same cycle: no drop, `count` stays 16.
- Clear/stop priority: assert `clear`, `stop` and `arm` with a record in one cycle while in CAPTURE with `count`=5. Required response: IDLE, `count`=0, `overflow`=0, `drop_cnt`=0.
- Async reset: assert `rst`=0 mid-drain between clock edges. Required response: outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/proc_trace_recorder.sv
// proc_trace_recorder: captures committed-instruction trace records into a
// show-ahead FIFO. Capture can start on a PC trigger and stop after a set
// number of records. The FIFO is drained over a valid/ready read port.
//
// Read handshake: a record leaves the FIFO on a rising clk edge exactly when
// rd_val && rd_rdy. rd_val depends only on FIFO occupancy, never on rd_rdy.
// rd_addr/rd_data hold the head while rd_val=1 and read 0 otherwise.
//
// A trace record that arrives in the same cycle as clear or stop is discarded.
module proc_trace_recorder #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trace_val,
   input  logic [31:0]              trace_addr,
   input  logic [31:0]              trace_data,
   input  logic                     arm,
   input  logic                     stop,
   input  logic                     clear,
   input  logic                     trig_en,
   input  logic [31:0]              trig_addr,
   input  logic [15:0]              cap_limit,
   output logic                     rd_val,
   input  logic                     rd_rdy,
   output logic [31:0]              rd_addr,
   output logic [31:0]              rd_data,
   output logic [1:0]               state,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [15:0]              drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic [15:0]     drop_cnt_q, drop_cnt_d;
   logic [15:0]     sess_cnt_q, sess_cnt_d;
   logic [63:0]     mem_q [DEPTH];

   logic            trig_hit;
   logic            cap;
   logic            pop;
   logic            full;
   logic            store;
   logic            drop;

   // Show-ahead read port: head comes straight from storage, zeroed when empty.
   always_comb begin
      rd_val  = (count_q != '0);
      rd_addr = '0;
      rd_data = '0;
      if (rd_val) begin
         {rd_addr, rd_data} = mem_q[rd_ptr_q];
      end
   end

   // Next-state: FSM, FIFO pointers/occupancy, drop accounting, session count.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      sess_cnt_d = sess_cnt_q;

      trig_hit = trace_val && (trace_addr == trig_addr);
      cap      = 1'b0;
      if (!clear && !stop) begin
         if (state_q == S_CAPTURE) cap = trace_val;
         else if (state_q == S_ARMED) cap = trig_hit;
      end

      pop   = rd_val && rd_rdy;
      full  = (count_q == CW'(DEPTH));
      store = cap && (!full || pop);
      drop  = cap && full && !pop;

      if (clear) begin
         state_d    = S_IDLE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
         sess_cnt_d = '0;
      end else begin
         if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
         if (store) wr_ptr_d = wr_ptr_q + PW'(1);
         count_d = count_q + CW'(store) - CW'(pop);
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
         end
         if (cap) sess_cnt_d = sess_cnt_q + 16'd1;

         if (stop) begin
            // stop outranks arm; it only ends an active session.
            if (state_q == S_ARMED || state_q == S_CAPTURE) state_d = S_DONE;
         end else begin
            unique case (state_q)
               S_IDLE, S_DONE: begin
                  if (arm) begin
                     sess_cnt_d = '0;
                     state_d    = trig_en ? S_ARMED : S_CAPTURE;
                  end
               end
               S_ARMED: begin
                  if (trig_hit) state_d = S_CAPTURE;
               end
               S_CAPTURE: ;
               default: state_d = S_IDLE;
            endcase
            // Limit reached on this record: finish at the same edge.
            if (cap && cap_limit != 16'd0 && sess_cnt_d == cap_limit) state_d = S_DONE;
         end
      end
   end

   // Control and pointer registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         sess_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         sess_cnt_q <= sess_cnt_d;
      end
   end

   // Record storage; contents are don't-care until written, reads are gated by count.
   always_ff @(posedge clk) begin
      if (store) mem_q[wr_ptr_q] <= {trace_addr, trace_data};
   end

   assign state    = state_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_proc_trace_recorder.sv
// Bench for proc_trace_recorder: records that should be stored are queued as
// expected values when driven and compared when the FIFO hands them out.
module tb_proc_trace_recorder;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trace_val = 1'b0;
   logic [31:0] trace_addr = '0;
   logic [31:0] trace_data = '0;
   logic        arm = 1'b0;
   logic        stop = 1'b0;
   logic        clear = 1'b0;
   logic        trig_en = 1'b0;
   logic [31:0] trig_addr = '0;
   logic [15:0] cap_limit = '0;
   logic        rd_val;
   logic        rd_rdy = 1'b0;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  state;
   logic [4:0]  count;
   logic        overflow;
   logic [15:0] drop_cnt;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   proc_trace_recorder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .trace_val(trace_val), .trace_addr(trace_addr),
      .trace_data(trace_data), .arm(arm), .stop(stop), .clear(clear),
      .trig_en(trig_en), .trig_addr(trig_addr), .cap_limit(cap_limit),
      .rd_val(rd_val), .rd_rdy(rd_rdy), .rd_addr(rd_addr), .rd_data(rd_data),
      .state(state), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_rec(input logic [31:0] a, input logic [31:0] d, input bit stored);
      trace_val  = 1'b1;
      trace_addr = a;
      trace_data = d;
      if (stored) exp_q.push_back({a, d});
      tick();
      trace_val = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Pop everything with rd_rdy held high, comparing each head to the queue.
   task automatic drain(input string tag);
      logic [63:0] e;
      int guard;
      guard = 0;
      rd_rdy = 1'b1;
      while (rd_val && guard < 4 * DEPTH) begin
         if (exp_q.size() == 0) begin
            check({tag, "_extra"}, {rd_addr, rd_data}, 64'h0);
            break;
         end
         e = exp_q.pop_front();
         check({tag, "_rec"}, {rd_addr, rd_data}, e);
         tick();
         guard++;
      end
      rd_rdy = 1'b0;
      check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
      check({tag, "_rdval_low"}, {63'd0, rd_val}, 64'd0);
      check({tag, "_rd_zero"}, {rd_addr, rd_data}, 64'd0);
   endtask

   initial begin
      // reset
      #12;
      check("rst_state", 64'(state), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_rd", {63'd0, rd_val}, 64'd0);
      check("rst_rd_out", {rd_addr, rd_data}, 64'd0);
      check("rst_ovf", {63'd0, overflow}, 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      rst = 1'b1;
      tick();

      // basic capture
      trig_en = 1'b0; cap_limit = 16'd0;
      pulse_arm();
      check("basic_state_cap", 64'(state), 64'd2);
      send_rec(32'h200, 32'h5, 1'b1);
      check("basic_first_lat", {63'd0, rd_val}, 64'd1);
      send_rec(32'h204, 32'h7, 1'b1);
      send_rec(32'h208, 32'hC, 1'b1);
      check("basic_count", 64'(count), 64'd3);
      drain("basic");
      check("basic_state_after", 64'(state), 64'd2);
      pulse_clear();
      check("basic_idle", 64'(state), 64'd0);

      // trigger
      trig_en = 1'b1; trig_addr = 32'h20C;
      pulse_arm();
      check("trig_armed", 64'(state), 64'd1);
      for (int pc = 32'h200; pc <= 32'h214; pc += 4) begin
         send_rec(32'(pc), 32'(pc + 1), pc >= 32'h20C);
         check("trig_state", 64'(state), (pc >= 32'h20C) ? 64'd2 : 64'd1);
      end
      check("trig_count", 64'(count), 64'd3);
      drain("trig");
      pulse_clear();

      // limit
      trig_en = 1'b0; cap_limit = 16'd2;
      pulse_arm();
      send_rec(32'h200, 32'hA0, 1'b1);
      check("lim_state1", 64'(state), 64'd2);
      send_rec(32'h204, 32'hA1, 1'b1);
      check("lim_done", 64'(state), 64'd3);
      send_rec(32'h208, 32'hA2, 1'b0);
      check("lim_count", 64'(count), 64'd2);
      check("lim_still_done", 64'(state), 64'd3);
      drain("lim");
      cap_limit = 16'd0;
      pulse_arm();
      check("rearm_cap", 64'(state), 64'd2);
      pulse_clear();

      // overflow
      pulse_arm();
      for (int i = 0; i < 20; i++) begin
         send_rec(32'h1000 + 32'(i * 4), $urandom, i < DEPTH);
      end
      check("ovf_count", 64'(count), 64'd16);
      check("ovf_flag", {63'd0, overflow}, 64'd1);
      check("ovf_drop", 64'(drop_cnt), 64'd4);
      check("ovf_head", {rd_addr, rd_data}, exp_q[0]);
      // push and pop in one cycle while full
      rd_rdy = 1'b1;
      check("ovf_pp_head", {rd_addr, rd_data}, exp_q.pop_front());
      send_rec(32'h2000, 32'hBEEF, 1'b1);
      rd_rdy = 1'b0;
      check("ovf_pp_count", 64'(count), 64'd16);
      check("ovf_pp_drop", 64'(drop_cnt), 64'd4);
      drain("ovf");

      // clear/stop/arm priority with overflow still set
      for (int i = 0; i < 5; i++) send_rec(32'h3000 + 32'(i), 32'(i), 1'b1);
      check("prio_pre_count", 64'(count), 64'd5);
      clear = 1'b1; stop = 1'b1; arm = 1'b1;
      trace_val = 1'b1; trace_addr = 32'h4000; trace_data = 32'h1;
      tick();
      clear = 1'b0; stop = 1'b0; arm = 1'b0; trace_val = 1'b0;
      exp_q.delete();
      check("prio_state", 64'(state), 64'd0);
      check("prio_count", 64'(count), 64'd0);
      check("prio_ovf", {63'd0, overflow}, 64'd0);
      check("prio_drop", 64'(drop_cnt), 64'd0);
      check("prio_rdval", {63'd0, rd_val}, 64'd0);

      // async reset mid-drain
      pulse_arm();
      for (int i = 0; i < 4; i++) send_rec(32'h5000 + 32'(i * 4), 32'(i + 9), 1'b1);
      rd_rdy = 1'b1;
      check("ar_head", {rd_addr, rd_data}, exp_q.pop_front());
      tick();
      check("ar_count", 64'(count), 64'd3);
      #2;
      rst = 1'b0;
      #1;
      check("ar_state", 64'(state), 64'd0);
      check("ar_count0", 64'(count), 64'd0);
      check("ar_rdval", {63'd0, rd_val}, 64'd0);
      check("ar_rd_out", {rd_addr, rd_data}, 64'd0);
      rd_rdy = 1'b0;
      exp_q.delete();
      #2;
      rst = 1'b1;
      tick();
      check("ar_post_state", 64'(state), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Overall time bound.
   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: got no finish expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
